// File: rtl/merge_stream_reader.sv
// Captures one sorted 2n-element vector and streams it out one element per valid/ready handshake.
// First element is valid 1 cycle after start. out_ready=0 holds data, index and valid stable.
module merge_stream_reader #(
  parameter int WIDTH = 3,
  parameter int n     = 128,
  localparam int IDXW = $clog2(2*n)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   order,
  input  logic [2*n*WIDTH-1:0]   in_vec,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDXW-1:0]        out_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(2*n-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef logic [2*n-1:0][WIDTH-1:0] vec_t;

  state_t           state_q, state_d;
  vec_t             shadow_q, shadow_d;
  logic             order_q, order_d;
  logic [IDXW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  vec_t             in_elems;
  logic [IDXW-1:0]  cnt_next;
  logic             at_last;

  assign in_elems = in_vec;
  assign cnt_next = order_q ? (cnt_q - 1'b1) : (cnt_q + 1'b1);
  assign at_last  = order_q ? (cnt_q == '0) : (cnt_q == LAST_IDX);

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    order_d    = order_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shadow_d   = in_elems;
          order_d    = order;
          cnt_d      = order ? LAST_IDX : '0;
          // Preload the first element straight from the capture so it is valid on the first STREAM cycle.
          out_data_d = order ? in_elems[LAST_IDX] : in_elems[0];
          state_d    = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = S_DONE;
          end else begin
            cnt_d      = cnt_next;
            out_data_d = shadow_q[cnt_next];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      order_q    <= 1'b0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      order_q    <= order_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_index = cnt_q;
  assign out_valid = (state_q == S_STREAM);
  assign out_last  = (state_q == S_STREAM) && at_last;
  assign busy      = (state_q == S_STREAM) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_merge_stream_reader.sv
// Directed bench for merge_stream_reader: small n=4 instance plus a default n=128 instance.
module tb_merge_stream_reader;

  localparam int W  = 3;
  localparam int NA = 4;
  localparam int NB = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                start_a, order_a, ready_a;
  logic [2*NA*W-1:0]   vec_a;
  logic [W-1:0]        data_a;
  logic [2:0]          index_a;
  logic                valid_a, last_a, busy_a, done_a;

  logic                start_b, order_b, ready_b;
  logic [2*NB*W-1:0]   vec_b;
  logic [W-1:0]        data_b;
  logic [7:0]          index_b;
  logic                valid_b, last_b, busy_b, done_b;

  merge_stream_reader #(.WIDTH(W), .n(NA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .order(order_a), .in_vec(vec_a),
    .out_data(data_a), .out_index(index_a), .out_valid(valid_a), .out_ready(ready_a),
    .out_last(last_a), .busy(busy_a), .done(done_a)
  );

  merge_stream_reader dut_b (
    .clk(clk), .rst(rst), .start(start_b), .order(order_b), .in_vec(vec_b),
    .out_data(data_b), .out_index(index_b), .out_valid(valid_b), .out_ready(ready_b),
    .out_last(last_b), .busy(busy_b), .done(done_b)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_b [2*NB];
  int busy_cnt, e, k, cyc;
  int pat [4] = '{1, 0, 0, 1};
  int v;

  initial begin
    rst = 1'b1;
    start_a = 1'b0; order_a = 1'b0; ready_a = 1'b0; vec_a = '0;
    start_b = 1'b0; order_b = 1'b0; ready_b = 1'b0; vec_b = '0;
    #2;
    check("rst_valid", 32'(valid_a), 0);
    check("rst_busy",  32'(busy_a),  0);
    check("rst_done",  32'(done_a),  0);
    check("rst_last",  32'(last_a),  0);
    check("rst_data",  32'(data_a),  0);
    check("rst_index", 32'(index_a), 0);
    check("rst_b_valid", 32'(valid_b), 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 2*NA; i++) vec_a[i*W +: W] = W'(i);

    // ascending, continuous ready
    start_a = 1'b1; order_a = 1'b0; ready_a = 1'b1; busy_cnt = 0;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 2*NA; i++) begin
      check("asc_valid", 32'(valid_a), 1);
      check("asc_data",  32'(data_a),  32'(i));
      check("asc_index", 32'(index_a), 32'(i));
      check("asc_last",  32'(last_a),  (i == 7) ? 1 : 0);
      busy_cnt += int'(busy_a);
      tick();
    end
    check("asc_done",       32'(done_a),  1);
    check("asc_done_valid", 32'(valid_a), 0);
    busy_cnt += int'(busy_a);
    tick();
    check("asc_done_clr", 32'(done_a), 0);
    check("asc_idle_busy", 32'(busy_a), 0);
    busy_cnt += int'(busy_a);
    check("asc_busy_cycles", 32'(busy_cnt), 9);

    // descending
    start_a = 1'b1; order_a = 1'b1;
    tick();
    start_a = 1'b0; order_a = 1'b0;
    for (int i = 0; i < 2*NA; i++) begin
      e = 7 - i;
      check("dsc_valid", 32'(valid_a), 1);
      check("dsc_data",  32'(data_a),  32'(e));
      check("dsc_index", 32'(index_a), 32'(e));
      check("dsc_last",  32'(last_a),  (e == 0) ? 1 : 0);
      tick();
    end
    check("dsc_done", 32'(done_a), 1);
    tick();

    // ascending with ready pattern 1,0,0,1
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    e = 0; cyc = 0;
    while (e < 8 && cyc < 40) begin
      ready_a = pat[cyc % 4][0];
      check("bp_valid", 32'(valid_a), 1);
      check("bp_data",  32'(data_a),  32'(e));
      check("bp_index", 32'(index_a), 32'(e));
      tick();
      if (ready_a) e++;
      cyc++;
    end
    check("bp_count", 32'(e), 8);
    check("bp_done",  32'(done_a), 1);
    ready_a = 1'b1;
    tick();

    // start pulsed mid-stream with all-5s vector, held through DONE
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 2*NA; i++) begin
      if (i == 3) begin
        start_a = 1'b1;
        for (int j = 0; j < 2*NA; j++) vec_a[j*W +: W] = 3'd5;
      end
      check("mid_data",  32'(data_a),  32'(i));
      check("mid_index", 32'(index_a), 32'(i));
      tick();
    end
    check("mid_done", 32'(done_a), 1);
    tick();
    check("mid_idle_busy",  32'(busy_a),  0);
    check("mid_idle_valid", 32'(valid_a), 0);
    tick();
    start_a = 1'b0;
    check("recap_valid", 32'(valid_a), 1);
    check("recap_data",  32'(data_a),  5);
    check("recap_index", 32'(index_a), 0);

    // asynchronous reset mid-stream while stalled at index 3
    tick(); tick(); tick();
    check("pre_rst_index", 32'(index_a), 3);
    ready_a = 1'b0;
    tick();
    check("stall_index", 32'(index_a), 3);
    check("stall_data",  32'(data_a),  5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(valid_a), 0);
    check("arst_busy",  32'(busy_a),  0);
    check("arst_done",  32'(done_a),  0);
    check("arst_index", 32'(index_a), 0);
    check("arst_data",  32'(data_a),  0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 2*NA; i++) vec_a[i*W +: W] = W'(i);
    tick();
    check("post_rst_busy", 32'(busy_a), 0);
    start_a = 1'b1; ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("post_rst_valid", 32'(valid_a), 1);
    check("post_rst_data",  32'(data_a),  0);
    check("post_rst_index", 32'(index_a), 0);
    for (int i = 0; i < 2*NA; i++) tick();
    check("post_rst_done", 32'(done_a), 1);
    tick();

    // n=128: random sorted vector, random ready
    v = 0;
    for (int i = 0; i < 2*NB; i++) begin
      if (v < 7 && $urandom_range(0, 31) == 0) v++;
      exp_b[i] = W'(v);
      vec_b[i*W +: W] = W'(v);
    end
    start_b = 1'b1; order_b = 1'b0;
    tick();
    start_b = 1'b0;
    vec_b = '1;
    k = 0; cyc = 0;
    while (k < 2*NB && cyc < 3000) begin
      ready_b = 1'($urandom_range(0, 1));
      check("big_valid", 32'(valid_b), 1);
      if (ready_b) begin
        check("big_data",  32'(data_b),  32'(exp_b[k]));
        check("big_index", 32'(index_b), 32'(k));
        check("big_last",  32'(last_b),  (k == 2*NB-1) ? 1 : 0);
        k++;
      end
      tick();
      cyc++;
    end
    check("big_count", 32'(k), 32'(2*NB));
    check("big_done",  32'(done_b),  1);
    check("big_busy",  32'(busy_b),  1);
    check("big_done_valid", 32'(valid_b), 0);
    tick();
    check("big_idle_busy", 32'(busy_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/merge_stream_reader.md
Name: merge_stream_reader

Overview:
- Reader end of the odd-even merge network. Captures one sorted 2n-element vector from the merge output bus and streams it out one element per handshake.
- Sits between the merge tree output and narrow downstream consumers (priority selector, V2V message builder). Replaces wide fan-out of the merge output.

Parameters:
WIDTH, 3, bits per element (same as the merge tree).
n, 128, half-vector size; the vector holds 2*n elements. Legal values are powers of two, 2 or larger.
IDXW (localparam), $clog2(2*n), width of the element index.

Ports:
clk  input  1  system clock, all state on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  capture in_vec and begin streaming (accepted only in IDLE)
order  input  1  sampled with start: 0 = ascending, element 0 first; 1 = descending, element 2n-1 first
in_vec  input  2*n*WIDTH  sorted vector from the merge tree; element k is in_vec[(k+1)*WIDTH-1:k*WIDTH]
out_data  output  WIDTH  current element
out_index  output  IDXW  vector position of out_data
out_valid  output  1  out_data/out_index valid
out_ready  input  1  consumer accepts the element
out_last  output  1  current element is the final one of the stream
busy  output  1  high in STREAM and DONE
done  output  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (asynchronous assert, any state): state goes to IDLE.
  - out_valid, out_last, busy and done are 0.
  - out_data, out_index, the shadow register and the counter are 0.
  - Takes effect immediately, mid-stream included. No partial transfer completes after reset.
- States: IDLE, STREAM, DONE.
- IDLE:
  - start=1 at an edge loads the shadow register with in_vec and latches order.
  - Counter loads 0 (ascending) or 2n-1 (descending). Next state is STREAM.
  - in_vec is don't-care outside the capture edge.
- STREAM:
  - out_valid=1.
  - out_data = shadow element at the counter; out_index = counter. Both are registered and valid from the first STREAM cycle, so latency from start edge to first out_valid is 1 cycle.
  - A transfer occurs on an edge with out_valid & out_ready.
  - After each transfer the counter steps +1 (ascending) or -1 (descending).
  - With out_ready=0, out_data, out_index and out_valid hold stable indefinitely (AXI-style: valid never drops without a transfer).
  - out_last=1 when the counter equals 2n-1 (ascending) or 0 (descending).
  - A transfer with out_last=1 moves the state to DONE. The counter does not wrap.
- DONE: lasts exactly one cycle. done=1, out_valid=0, busy=1. Next state is IDLE.
- start while in STREAM or DONE is ignored, with no recapture and no effect on the stream. start held high through DONE is accepted on the first IDLE edge.
- Sustained throughput is one element per cycle with out_ready=1 continuously. A full stream takes 2n cycles plus 1 DONE cycle, so the minimum start-to-start spacing is 2n+2 cycles.
- out_index is IDXW bits. Descending stepping from 0 never occurs because DONE is taken first.
- Element selection is a registered mux from the shadow register (no combinational path from in_vec to out_data).

Test Plan:
- n=4, WIDTH=3, in_vec elements 0..7 = {0,1,2,3,4,5,6,7}, order=0, out_ready=1 -> out_data 0..7 on 8 consecutive cycles starting 1 cycle after start; out_index 0..7; out_last only on 7; done pulse the next cycle; busy is 9 cycles.
- Same vector, order=1 -> out_data 7,6,...,0; out_index 7..0; out_last on index 0.
- order=0 with out_ready toggled 1,0,0,1,... -> every element appears exactly once in order; out_data and out_index are stable while out_ready=0.
- start pulsed mid-stream with a different in_vec (all 5s) -> the original stream continues unchanged and no 5s appear; start held through DONE begins a new capture on the first IDLE cycle.
- Assert rst while out_index=3 and out_ready=0 -> out_valid, busy and done go to 0 immediately (asynchronous). After release the block is IDLE, and a fresh start streams from index 0.
- Default n=128, WIDTH=3, random sorted 256-element vector, random out_ready -> a scoreboard matches all 256 elements in order with out_last on element 255.
